wash_session_ctrl: RTL and testbench

Customer-facing front end for the washing machine controller. It counts coins from the coin mechanism, prices single and double washes, and launches the controller with a one-cycle `coin_in` pulse and a held `double_wash` level. While the wash runs it drives `timer_pause` from the lid switch and watches for `wash_done` or a timeout. It sits between the panel and coin hardware on one side and `Washing_Machine_Controller` on the other, on the same clock.

---
 rtl/wash_pkg.sv | 24 ++
 rtl/wash_session_ctrl_rise_detect.sv | 25 ++
 rtl/wash_session_ctrl.sv | 171 +++++++++++++++++
 tb/tb_wash_session_ctrl.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wash_pkg.sv
// Shared types and default constants for the wash session front end.
// Pulled in by the session controller and its edge detectors.
package wash_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LAUNCH,
        ST_RUN,
        ST_FINISH,
        ST_REFUND
    } wash_sess_state_t;

    localparam int DEF_PRICE_SINGLE = 1;
    localparam int DEF_PRICE_DOUBLE = 2;
    localparam int DEF_MAX_CREDIT   = 7;
    localparam int DEF_CREDIT_W     = 3;
    localparam int DEF_RUN_TIMEOUT  = 4096;

    // Width of a counter that must hold 0 .. timeout-1.
    function automatic int tmr_width(input int timeout);
        return (timeout > 2) ? $clog2(timeout) : 1;
    endfunction

endpackage

// File: rtl/wash_session_ctrl_rise_detect.sv
// One-flop rising-edge detector; the event is the current level
// with the previous sampled level low.
module rise_detect (
    input  logic clk,
    input  logic reset_n,
    input  logic d,
    output logic rise
);

    logic prev_d;
    logic prev_q;

    always_comb prev_d = d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prev_q <= 1'b0;
        end else begin
            prev_q <= prev_d;
        end
    end

    assign rise = d & ~prev_q;

endmodule

// File: rtl/wash_session_ctrl.sv
// Coin counting, pricing and session sequencing in front of the
// washing machine controller; all outputs come straight from flops.
module wash_session_ctrl
    import wash_pkg::*;
#(
    parameter int PRICE_SINGLE = DEF_PRICE_SINGLE,
    parameter int PRICE_DOUBLE = DEF_PRICE_DOUBLE,
    parameter int MAX_CREDIT   = DEF_MAX_CREDIT,
    parameter int CREDIT_W     = DEF_CREDIT_W,
    parameter int RUN_TIMEOUT  = DEF_RUN_TIMEOUT
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                coin_sense,
    input  logic                sel_double,
    input  logic                start_btn,
    input  logic                cancel_btn,
    input  logic                lid_open,
    input  logic                wash_done,
    output logic                coin_in,
    output logic                double_wash,
    output logic                timer_pause,
    output logic [CREDIT_W-1:0] credit,
    output logic                refund_pulse,
    output logic                busy,
    output logic                fault
);

    localparam int TW = tmr_width(RUN_TIMEOUT);
    localparam int SW = CREDIT_W + 1;
    localparam logic [SW-1:0] P_SINGLE = SW'(PRICE_SINGLE);
    localparam logic [SW-1:0] P_DOUBLE = SW'(PRICE_DOUBLE);
    localparam logic [SW-1:0] MAX_C    = SW'(MAX_CREDIT);
    localparam logic [TW-1:0] TMR_LAST = TW'(RUN_TIMEOUT - 1);

    logic coin_ev, start_ev, cancel_ev, done_ev;

    rise_detect u_coin   (.clk(clk), .reset_n(reset_n), .d(coin_sense), .rise(coin_ev));
    rise_detect u_start  (.clk(clk), .reset_n(reset_n), .d(start_btn),  .rise(start_ev));
    rise_detect u_cancel (.clk(clk), .reset_n(reset_n), .d(cancel_btn), .rise(cancel_ev));
    rise_detect u_done   (.clk(clk), .reset_n(reset_n), .d(wash_done),  .rise(done_ev));

    wash_sess_state_t    state_q, state_d;
    logic [CREDIT_W-1:0] credit_q, credit_d;
    logic [TW-1:0]       tmr_q, tmr_d;
    logic                drain_q, drain_d;
    logic                pend_q, pend_d;
    logic                coin_in_q, coin_in_d;
    logic                dw_q, dw_d;
    logic                pause_q, pause_d;
    logic                refund_q, refund_d;
    logic                busy_q, busy_d;
    logic                fault_q, fault_d;

    logic [SW-1:0] price;
    logic [SW-1:0] sum;
    logic          take, dec, sat, extra;

    always_comb begin
        state_d = state_q;
        dw_d    = dw_q;
        tmr_d   = tmr_q;
        fault_d = fault_q;
        drain_d = 1'b0;
        take    = 1'b0;
        dec     = 1'b0;
        price   = sel_double ? P_DOUBLE : P_SINGLE;

        unique case (state_q)
            ST_IDLE: begin
                if (start_ev && ({1'b0, credit_q} >= price)) begin
                    take    = 1'b1;
                    dw_d    = sel_double;
                    state_d = ST_LAUNCH;
                end else if (cancel_ev && (credit_q != '0)) begin
                    drain_d = 1'b1;
                    state_d = ST_REFUND;
                end
            end
            ST_LAUNCH: begin
                tmr_d   = '0;
                state_d = ST_RUN;
            end
            ST_RUN: begin
                // A done event in the last allowed cycle beats the timeout.
                if (done_ev) begin
                    state_d = ST_FINISH;
                end else if (!pause_q) begin
                    if (tmr_q == TMR_LAST) begin
                        fault_d = 1'b1;
                        state_d = ST_FINISH;
                    end else begin
                        tmr_d = tmr_q + 1'b1;
                    end
                end
            end
            ST_FINISH: begin
                dw_d    = 1'b0;
                state_d = ST_IDLE;
            end
            ST_REFUND: begin
                if (drain_q) begin
                    dec = 1'b1;
                end else begin
                    drain_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        sum      = {1'b0, credit_q} + SW'(coin_ev) - (take ? price : '0) - SW'(dec);
        sat      = coin_ev && (sum > MAX_C);
        credit_d = sat ? credit_q : sum[CREDIT_W-1:0];

        if (dec && (credit_d == '0)) begin
            state_d = ST_IDLE;
        end

        // A rejected coin rides on a free slot, else waits one behind the drain.
        extra = sat | pend_q;
        if (drain_d) begin
            refund_d = 1'b1;
            pend_d   = extra;
        end else begin
            refund_d = extra;
            pend_d   = sat & pend_q;
        end

        coin_in_d = (state_d == ST_LAUNCH);
        busy_d    = (state_d == ST_LAUNCH) || (state_d == ST_RUN) ||
                    (state_d == ST_FINISH);
        pause_d   = (state_d == ST_RUN) && lid_open;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            credit_q  <= '0;
            tmr_q     <= '0;
            drain_q   <= 1'b0;
            pend_q    <= 1'b0;
            coin_in_q <= 1'b0;
            dw_q      <= 1'b0;
            pause_q   <= 1'b0;
            refund_q  <= 1'b0;
            busy_q    <= 1'b0;
            fault_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            credit_q  <= credit_d;
            tmr_q     <= tmr_d;
            drain_q   <= drain_d;
            pend_q    <= pend_d;
            coin_in_q <= coin_in_d;
            dw_q      <= dw_d;
            pause_q   <= pause_d;
            refund_q  <= refund_d;
            busy_q    <= busy_d;
            fault_q   <= fault_d;
        end
    end

    assign coin_in      = coin_in_q;
    assign double_wash  = dw_q;
    assign timer_pause  = pause_q;
    assign credit       = credit_q;
    assign refund_pulse = refund_q;
    assign busy         = busy_q;
    assign fault        = fault_q;

endmodule

// File: tb/tb_wash_session_ctrl.sv
// Scoreboard bench: tasks issue sessions and queue expected responses,
// a negedge monitor pops and compares whatever the DUT presents.
module tb_wash_session_ctrl;

    localparam int PS   = 1;
    localparam int PD   = 2;
    localparam int MAXC = 7;
    localparam int CW   = 3;
    localparam int TMO  = 16;

    logic clk = 1'b0;
    logic reset_n = 1'b1;
    logic coin_sense = 1'b0, sel_double = 1'b0, start_btn = 1'b0;
    logic cancel_btn = 1'b0, lid_open = 1'b0, wash_done = 1'b0;
    logic coin_in, double_wash, timer_pause, refund_pulse, busy, fault;
    logic [CW-1:0] credit;

    wash_session_ctrl #(
        .PRICE_SINGLE(PS), .PRICE_DOUBLE(PD), .MAX_CREDIT(MAXC),
        .CREDIT_W(CW), .RUN_TIMEOUT(TMO)
    ) dut (
        .clk(clk), .reset_n(reset_n), .coin_sense(coin_sense),
        .sel_double(sel_double), .start_btn(start_btn),
        .cancel_btn(cancel_btn), .lid_open(lid_open),
        .wash_done(wash_done), .coin_in(coin_in),
        .double_wash(double_wash), .timer_pause(timer_pause),
        .credit(credit), .refund_pulse(refund_pulse), .busy(busy),
        .fault(fault)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { int cyc; logic dw; int cr; } launch_t;
    typedef struct { int cyc; logic fl; } done_t;
    typedef struct { int cyc; int cr; logic fl; logic dw; logic tp; logic bz; } probe_t;

    launch_t lq[$];
    done_t   dq[$];
    probe_t  pq[$];
    int      rq[$];

    int n_chk = 0;
    int n_pass = 0;
    int m_credit = 0;
    logic m_fault = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s @cyc %0d: got %0d expected %0d", nm, cyc, act, exp);
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push_probe(input int c, input int cr, input logic fl,
                              input logic dw, input logic tp, input logic bz);
        probe_t p;
        p.cyc = c; p.cr = cr; p.fl = fl; p.dw = dw; p.tp = tp; p.bz = bz;
        pq.push_back(p);
    endtask

    task automatic push_launch(input int c, input logic dw, input int cr);
        launch_t l;
        l.cyc = c; l.dw = dw; l.cr = cr;
        lq.push_back(l);
    endtask

    task automatic push_done(input int c, input logic fl);
        done_t d;
        d.cyc = c; d.fl = fl;
        dq.push_back(d);
    endtask

    // Monitor: every presented event must match the head of its queue.
    logic    busy_prev = 1'b0;
    launch_t ml;
    done_t   md;
    probe_t  mp;
    always @(negedge clk) begin
        if (coin_in === 1'b1) begin
            if (lq.size() == 0) chk("launch_unexpected", 1, 0);
            else begin
                ml = lq.pop_front();
                chk("launch_cycle", cyc, ml.cyc);
                chk("launch_double_wash", double_wash, ml.dw);
                chk("launch_credit", credit, ml.cr);
            end
        end
        if (refund_pulse === 1'b1) begin
            if (rq.size() == 0) chk("refund_unexpected", 1, 0);
            else chk("refund_cycle", cyc, rq.pop_front());
        end
        if (busy_prev && busy !== 1'b1) begin
            if (dq.size() == 0) chk("busy_fall_unexpected", 1, 0);
            else begin
                md = dq.pop_front();
                chk("done_cycle", cyc, md.cyc);
                chk("done_fault", fault, md.fl);
                chk("done_double_wash", double_wash, 0);
            end
        end
        busy_prev = (busy === 1'b1);
        while (pq.size() > 0 && pq[0].cyc < cyc) begin
            mp = pq.pop_front();
            chk("probe_missed", mp.cyc, cyc);
        end
        if (pq.size() > 0 && pq[0].cyc == cyc) begin
            mp = pq.pop_front();
            chk("probe_credit", credit, mp.cr);
            chk("probe_fault", fault, mp.fl);
            chk("probe_double_wash", double_wash, mp.dw);
            chk("probe_timer_pause", timer_pause, mp.tp);
            chk("probe_busy", busy, mp.bz);
        end
    end

    task automatic do_coins(input int n);
        for (int i = 0; i < n; i++) begin
            coin_sense = 1'b1;
            if (m_credit + 1 > MAXC) rq.push_back(cyc + 1);
            else m_credit++;
            tick(1);
            coin_sense = 1'b0;
            tick(1);
        end
        push_probe(cyc + 1, m_credit, m_fault, 1'b0, 1'b0, 1'b0);
        tick(2);
    endtask

    task automatic do_cancel();
        int k, n;
        k = cyc;
        n = m_credit;
        cancel_btn = 1'b1;
        for (int i = 0; i < n; i++) rq.push_back(k + 1 + 2 * i);
        m_credit = 0;
        push_probe(k + ((n > 0) ? 2 * n : 1), 0, m_fault, 1'b0, 1'b0, 1'b0);
        tick(1);
        cancel_btn = 1'b0;
        tick((n > 0) ? 2 * n + 1 : 2);
    endtask

    // lid_mode: 0 closed, 1 random, 2 open for ten cycles; done_after < 0 never.
    task automatic do_session(input logic sel, input int done_after, input int lid_mode,
                              input int coin_at, input int btn_at);
        int s, price, d_cyc, t, e, cnt, xc, xb;
        logic to;
        logic lid [0:63];
        price = sel ? PD : PS;
        sel_double = sel;
        start_btn = 1'b1;
        s = cyc;
        if (m_credit < price) begin
            push_probe(s + 1, m_credit, m_fault, 1'b0, 1'b0, 1'b0);
            tick(1);
            start_btn = 1'b0;
            tick(2);
            return;
        end
        m_credit -= price;
        push_launch(s + 1, sel, m_credit);
        for (int j = 0; j < 64; j++) begin
            if (lid_mode == 2) lid[j] = (j >= 2 && j < 12);
            else if (lid_mode == 1) lid[j] = (j < 40) && ($urandom_range(0, 2) == 0);
            else lid[j] = 1'b0;
        end
        // Run cycles start at s+2; pause in cycle t is lid one cycle earlier.
        d_cyc = (done_after >= 0) ? s + 2 + done_after : 32'h7fffffff;
        cnt = 0;
        to = 1'b0;
        t = s + 2;
        while (t != d_cyc) begin
            if (!lid[t - s - 2]) begin
                cnt++;
                if (cnt == TMO) begin
                    to = 1'b1;
                    break;
                end
            end
            t++;
        end
        e = t;
        xc = (coin_at >= 0 && s + 2 + coin_at <= e + 1) ? s + 2 + coin_at : -1;
        xb = (btn_at >= 0 && s + 3 + btn_at <= e) ? s + 3 + btn_at : -1;
        for (int c = s + 2; c <= e; c++)
            push_probe(c, m_credit + ((xc >= 0 && c > xc) ? 1 : 0), m_fault,
                       sel, lid[c - s - 2], 1'b1);
        if (xc >= 0) m_credit++;
        if (to) m_fault = 1'b1;
        push_probe(e + 2, m_credit, m_fault, 1'b0, 1'b0, 1'b0);
        push_done(e + 2, m_fault);
        for (int c = s + 1; c <= e + 1; c++) begin
            tick(1);
            start_btn  = (c == xb);
            cancel_btn = (c == xb);
            lid_open   = lid[c - s - 1];
            coin_sense = (c == xc);
            wash_done  = (c == d_cyc);
        end
        tick(1);
        start_btn = 1'b0; cancel_btn = 1'b0; lid_open = 1'b0;
        coin_sense = 1'b0; wash_done = 1'b0;
        tick(2);
    endtask

    initial begin
        #800000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int op, r, da;
        #1 reset_n = 1'b0;
        tick(3);
        push_probe(cyc, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick(1);
        reset_n = 1'b1;
        push_probe(cyc + 1, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick(2);

        do_coins(1);
        do_session(1'b0, 5, 0, -1, -1);
        do_coins(1);
        do_session(1'b1, 5, 0, -1, -1);
        do_coins(1);
        do_session(1'b1, 6, 1, 2, 1);
        do_coins(9);
        do_cancel();
        do_coins(3);
        do_cancel();
        do_cancel();
        do_coins(1);
        do_session(1'b0, -1, 2, -1, -1);
        do_coins(2);
        do_session(1'b1, 3, 0, -1, -1);

        for (int i = 0; i < 70; i++) begin
            op = $urandom_range(0, 9);
            if (op < 4) do_coins($urandom_range(1, 4));
            else if (op < 8) begin
                r = $urandom_range(0, 30);
                da = (r > 24) ? -1 : r;
                do_session(1'($urandom_range(0, 1)), da, $urandom_range(0, 1),
                           ($urandom_range(0, 1) == 1) ? $urandom_range(0, 20) : -1,
                           ($urandom_range(0, 1) == 1) ? $urandom_range(0, 20) : -1);
            end else do_cancel();
        end

        // Reset in the middle of a run drops everything without refunds.
        do_coins(2);
        sel_double = 1'b0;
        start_btn = 1'b1;
        m_credit -= PS;
        push_launch(cyc + 1, 1'b0, m_credit);
        tick(1);
        start_btn = 1'b0;
        tick(4);
        push_done(cyc, 1'b0);
        push_probe(cyc, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        reset_n = 1'b0;
        m_credit = 0;
        m_fault = 1'b0;
        tick(2);
        reset_n = 1'b1;
        push_probe(cyc + 1, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick(3);
        do_coins(1);
        do_session(1'b0, 4, 1, 1, -1);

        tick(10);
        chk("launch_queue_left", lq.size(), 0);
        chk("refund_queue_left", rq.size(), 0);
        chk("done_queue_left", dq.size(), 0);
        chk("probe_queue_left", pq.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
